// File: rtl/layer_seq_if.sv
// Engine-side buses and shared DRAM port of the layer sequencer.
// The sequencer uses the master modport; engines and DRAM side use slave.
interface layer_seq_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned NUM_ENG    = 4
);
    logic                          rdy_data;
    logic [NUM_ENG-1:0]            eng_done;
    logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out;
    logic [NUM_ENG-1:0]            eng_wr;
    logic [NUM_ENG-1:0]            eng_rd;
    logic [NUM_ENG-1:0]            eng_en;
    logic [DATA_WIDTH-1:0]         data_out;
    logic [ADDR_WIDTH-1:0]         addr_in;
    logic [ADDR_WIDTH-1:0]         addr_out;
    logic                          dram_en_wr;
    logic                          dram_en_rd;

    modport master (
        input  rdy_data, eng_done, eng_data_out, eng_addr_in, eng_addr_out, eng_wr, eng_rd,
        output eng_en, data_out, addr_in, addr_out, dram_en_wr, dram_en_rd
    );

    modport slave (
        output rdy_data, eng_done, eng_data_out, eng_addr_in, eng_addr_out, eng_wr, eng_rd,
        input  eng_en, data_out, addr_in, addr_out, dram_en_wr, dram_en_rd
    );
endinterface

// File: rtl/layer_seq.sv
// Programmable layer sequencer: walks a run-time loaded stage table, enables one
// engine per stage and muxes that engine's DRAM interface onto the shared port.
module layer_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned NUM_ENG    = 4,
    parameter int unsigned ENG_W      = 2,
    parameter int unsigned TBL_DEPTH  = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [ENG_W-1:0] cfg_eng,
    input  logic             cfg_len_we,
    input  logic [IDX_W:0]   cfg_len,
    output logic [IDX_W-1:0] stage_idx,
    output logic             busy,
    output logic             done,
    output logic             done_one_layer,
    output logic             err,
    layer_seq_if.master      bus
);
    localparam int unsigned LEN_W = IDX_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [IDX_W-1:0]   stage_nxt;
    logic               dol_nxt;
    logic [LEN_W-1:0]   tbl_len;
    logic [ENG_W-1:0]   tbl [TBL_DEPTH];
    logic               rdy_data_ff;
    logic [ENG_W-1:0]   cur;
    logic [NUM_ENG-1:0] cur_onehot;
    logic               cur_valid;
    logic               cur_done;
    logic               other_done;
    logic               last_stage;
    logic               cfg_open;

    // Decode the current stage's engine; an id outside NUM_ENG yields an empty one-hot.
    always_comb begin
        cur        = tbl[stage_idx];
        cur_onehot = '0;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            cur_onehot[k] = (cur == ENG_W'(k));
        end
        cur_valid  = |cur_onehot;
        cur_done   = |(bus.eng_done & cur_onehot);
        other_done = |(bus.eng_done & ~cur_onehot);
        last_stage = ({1'b0, stage_idx} == (tbl_len - LEN_W'(1)));
        cfg_open   = (state == S_IDLE) || (state == S_DONE);
    end

    // Next-state logic; a stray done from a non-current engine beats the current one.
    always_comb begin
        state_nxt = state;
        stage_nxt = stage_idx;
        dol_nxt   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (enable && (tbl_len != '0)) begin
                    state_nxt = S_RUN;
                    stage_nxt = '0;
                end
            end
            S_RUN: begin
                if (!cur_valid || other_done) begin
                    state_nxt = S_ERR;
                end else if (cur_done) begin
                    dol_nxt = 1'b1;
                    if (last_stage) begin
                        state_nxt = S_DONE;
                    end else begin
                        stage_nxt = stage_idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state          <= S_IDLE;
            stage_idx      <= '0;
            rdy_data_ff    <= 1'b0;
            done_one_layer <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_nxt;
            stage_idx      <= stage_nxt;
            rdy_data_ff    <= bus.rdy_data;
            done_one_layer <= dol_nxt;
            busy           <= (state_nxt == S_RUN);
            done           <= (state_nxt == S_DONE);
            err            <= (state_nxt == S_ERR);
        end
    end

    // Stage table and length, writable only while no stage is executing.
    always_ff @(posedge clk) begin
        if (srst) begin
            tbl_len <= '0;
            for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            if (cfg_open && cfg_we) begin
                tbl[cfg_idx] <= cfg_eng;
            end
            if (cfg_open && cfg_len_we) begin
                tbl_len <= (cfg_len > LEN_W'(TBL_DEPTH)) ? LEN_W'(TBL_DEPTH) : cfg_len;
            end
        end
    end

    // Engine enable and combinational DRAM mux; everything is zero outside RUN.
    always_comb begin
        bus.eng_en     = '0;
        bus.data_out   = '0;
        bus.addr_in    = '0;
        bus.addr_out   = '0;
        bus.dram_en_wr = 1'b0;
        bus.dram_en_rd = 1'b0;
        if (state == S_RUN) begin
            bus.eng_en = cur_onehot & {NUM_ENG{rdy_data_ff}};
            for (int unsigned k = 0; k < NUM_ENG; k++) begin
                if (cur_onehot[k]) begin
                    bus.data_out   = bus.eng_data_out[k*DATA_WIDTH +: DATA_WIDTH];
                    bus.addr_in    = bus.eng_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
                    bus.addr_out   = bus.eng_addr_out[k*ADDR_WIDTH +: ADDR_WIDTH];
                    bus.dram_en_wr = bus.eng_wr[k];
                    bus.dram_en_rd = bus.eng_rd[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_layer_seq.sv
// Bench for layer_seq: directed scenarios plus randomized traffic, all outputs
// checked every cycle against a behavioural model of the sequencer.
module tb_layer_seq;
    localparam int DW = 32;
    localparam int AW = 18;
    localparam int NE = 4;
    localparam int EW = 2;
    localparam int TD = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          enable = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [EW-1:0] cfg_eng = '0;
    logic          cfg_len_we = 1'b0;
    logic [IW:0]   cfg_len = '0;
    logic [IW-1:0] stage_idx;
    logic          busy, done, done_one_layer, err;

    layer_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE)) bus ();

    layer_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .ENG_W(EW),
                .TBL_DEPTH(TD), .IDX_W(IW)) dut (
        .clk(clk), .srst(srst), .enable(enable),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_eng(cfg_eng),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
        .stage_idx(stage_idx), .busy(busy), .done(done),
        .done_one_layer(done_one_layer), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int dol_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle 1=run 2=done 3=error.
    int m_mode = 0;
    int m_tbl[TD];
    int m_len = 0;
    int m_stage = 0;
    bit m_rdy = 0;
    bit m_dol = 0;
    bit m_live = 0;

    task automatic model_step();
        int old_mode, cur, dn;
        if (srst) begin
            m_mode = 0; m_stage = 0; m_len = 0; m_rdy = 0; m_dol = 0; m_live = 1;
            for (int i = 0; i < TD; i++) m_tbl[i] = 0;
            return;
        end
        old_mode = m_mode;
        cur = m_tbl[m_stage];
        dn = int'(bus.eng_done);
        m_dol = 0;
        if (old_mode == 0 || old_mode == 2) begin
            if (enable && m_len > 0) begin m_mode = 1; m_stage = 0; end
            if (cfg_we) m_tbl[cfg_idx] = int'(cfg_eng);
            if (cfg_len_we) m_len = (int'(cfg_len) > TD) ? TD : int'(cfg_len);
        end else if (old_mode == 1) begin
            if (cur >= NE || (dn & ~(1 << cur)) != 0) m_mode = 3;
            else if (dn[cur]) begin
                m_dol = 1;
                if (m_stage == m_len - 1) m_mode = 2;
                else m_stage = m_stage + 1;
            end
        end
        m_rdy = bus.rdy_data;
    endtask

    task automatic compare_all();
        int cur;
        logic [NE-1:0] en_e;
        logic [DW-1:0] d_e;
        logic [AW-1:0] ai_e, ao_e;
        logic wr_e, rd_e;
        cur = m_tbl[m_stage];
        en_e = '0; d_e = '0; ai_e = '0; ao_e = '0; wr_e = 0; rd_e = 0;
        if (m_mode == 1 && cur < NE) begin
            if (m_rdy) en_e = NE'(1 << cur);
            d_e  = bus.eng_data_out[cur*DW +: DW];
            ai_e = bus.eng_addr_in[cur*AW +: AW];
            ao_e = bus.eng_addr_out[cur*AW +: AW];
            wr_e = bus.eng_wr[cur];
            rd_e = bus.eng_rd[cur];
        end
        check("eng_en", 64'(bus.eng_en), 64'(en_e));
        check("data_out", 64'(bus.data_out), 64'(d_e));
        check("addr_in", 64'(bus.addr_in), 64'(ai_e));
        check("addr_out", 64'(bus.addr_out), 64'(ao_e));
        check("dram_en_wr", 64'(bus.dram_en_wr), 64'(wr_e));
        check("dram_en_rd", 64'(bus.dram_en_rd), 64'(rd_e));
        check("stage_idx", 64'(stage_idx), 64'(m_stage));
        check("busy", 64'(busy), 64'(m_mode == 1));
        check("done", 64'(done), 64'(m_mode == 2));
        check("err", 64'(err), 64'(m_mode == 3));
        check("done_one_layer", 64'(done_one_layer), 64'(m_dol));
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_live) compare_all();
    end

    always @(negedge clk) if (done_one_layer) dol_cnt++;

    task automatic fixed_bus();
        for (int k = 0; k < NE; k++) begin
            bus.eng_data_out[k*DW +: DW] = 32'hD000_0000 | 32'(k);
            bus.eng_addr_in[k*AW +: AW]  = 18'h00100 | 18'(k);
            bus.eng_addr_out[k*AW +: AW] = 18'h00200 | 18'(k);
        end
        bus.eng_wr = 4'b1010;
        bus.eng_rd = 4'b0101;
    endtask

    task automatic random_bus();
        for (int k = 0; k < NE; k++) begin
            bus.eng_data_out[k*DW +: DW] = $urandom;
            bus.eng_addr_in[k*AW +: AW]  = 18'($urandom);
            bus.eng_addr_out[k*AW +: AW] = 18'($urandom);
        end
        bus.eng_wr = 4'($urandom);
        bus.eng_rd = 4'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk); srst = 1'b1;
        @(negedge clk); srst = 1'b0;
    endtask

    task automatic write_entry(input int idx, input int eng);
        @(negedge clk); cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_eng = EW'(eng);
        @(negedge clk); cfg_we = 1'b0;
    endtask

    task automatic write_len(input int len);
        @(negedge clk); cfg_len_we = 1'b1; cfg_len = (IW+1)'(len);
        @(negedge clk); cfg_len_we = 1'b0;
    endtask

    task automatic pulse_enable();
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
    endtask

    task automatic pulse_done(input logic [NE-1:0] v);
        bus.eng_done = v;
        @(negedge clk); bus.eng_done = '0;
    endtask

    int t1_tbl[6] = '{0, 1, 2, 0, 1, 2};
    logic [NE-1:0] t1_en[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        bus.rdy_data = 1'b0;
        bus.eng_done = '0;
        fixed_bus();
        repeat (2) @(negedge clk);
        srst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_eng_en", 64'(bus.eng_en), 64'd0);
        check("reset_stage", 64'(stage_idx), 64'd0);

        // Six-stage walk over engines 0,1,2,0,1,2.
        bus.rdy_data = 1'b1;
        for (int s = 0; s < 6; s++) write_entry(s, t1_tbl[s]);
        write_len(6);
        dol_cnt = 0;
        pulse_enable();
        for (int s = 0; s < 6; s++) begin
            repeat (9) @(negedge clk);
            check("t1_eng_en", 64'(bus.eng_en), 64'(t1_en[s]));
            pulse_done(NE'(1 << t1_tbl[s]));
        end
        @(negedge clk);
        check("t1_done", 64'(done), 64'd1);
        check("t1_stage", 64'(stage_idx), 64'd5);
        check("t1_layers", 64'(dol_cnt), 64'd6);

        // Restart from DONE with a rewritten one-entry table.
        write_entry(0, 3);
        write_len(1);
        pulse_enable();
        check("t2_eng_en", 64'(bus.eng_en), 64'h8);
        repeat (3) @(negedge clk);
        pulse_done(4'b1000);
        check("t2_done", 64'(done), 64'd1);

        // Stray done from engine 2 alongside engine 0's done.
        do_reset();
        write_entry(0, 0);
        write_entry(1, 1);
        write_len(2);
        pulse_enable();
        repeat (3) @(negedge clk);
        dol_cnt = 0;
        pulse_done(4'b0101);
        check("t3_err", 64'(err), 64'd1);
        check("t3_eng_en", 64'(bus.eng_en), 64'd0);
        check("t3_stage", 64'(stage_idx), 64'd0);
        @(negedge clk);
        check("t3_no_layer", 64'(dol_cnt), 64'd0);

        // rdy_data low gates the enable but not the DRAM mux.
        do_reset();
        bus.rdy_data = 1'b0;
        write_entry(0, 2);
        write_len(1);
        pulse_enable();
        check("t4_gated_en", 64'(bus.eng_en), 64'd0);
        check("t4_data", 64'(bus.data_out), 64'hD000_0002);
        check("t4_addr_in", 64'(bus.addr_in), 64'h00102);
        check("t4_rd", 64'(bus.dram_en_rd), 64'd1);
        bus.rdy_data = 1'b1;
        @(negedge clk);
        check("t4_en_after_rdy", 64'(bus.eng_en), 64'h4);

        // Empty table ignores enable; oversize length clamps to the table depth.
        do_reset();
        pulse_enable();
        repeat (2) @(negedge clk);
        check("t5_idle", 64'(busy), 64'd0);
        write_len(20);
        dol_cnt = 0;
        pulse_enable();
        for (int s = 0; s < TD; s++) begin
            @(negedge clk);
            pulse_done(4'b0001);
        end
        @(negedge clk);
        check("t5_done", 64'(done), 64'd1);
        check("t5_stage", 64'(stage_idx), 64'd15);
        check("t5_layers", 64'(dol_cnt), 64'd16);

        // Reset in the middle of stage 3.
        do_reset();
        for (int s = 0; s < 6; s++) write_entry(s, s % NE);
        write_len(6);
        pulse_enable();
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            pulse_done(NE'(1 << (s % NE)));
        end
        check("t6_stage3", 64'(stage_idx), 64'd3);
        do_reset();
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_stage", 64'(stage_idx), 64'd0);
        check("t6_eng_en", 64'(bus.eng_en), 64'd0);
        check("t6_data", 64'(bus.data_out), 64'd0);
        pulse_enable();
        @(negedge clk);
        check("t6_len_cleared", 64'(busy), 64'd0);

        // Randomized traffic checked by the model every cycle.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            random_bus();
            srst         = ($urandom_range(0, 199) == 0);
            bus.rdy_data = ($urandom_range(0, 3) != 0);
            enable       = ($urandom_range(0, 7) == 0);
            cfg_we       = ($urandom_range(0, 4) == 0);
            cfg_idx      = IW'($urandom);
            cfg_eng      = EW'($urandom);
            cfg_len_we   = ($urandom_range(0, 11) == 0);
            cfg_len      = (IW+1)'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 24) == 0) bus.eng_done = NE'($urandom);
                else bus.eng_done = NE'(1 << (m_tbl[m_stage] % NE));
            end else begin
                bus.eng_done = '0;
            end
        end
        @(negedge clk);
        srst = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0; bus.eng_done = '0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
